// File: rtl/fp16_mul_pipe.sv
// fp16_mul_pipe: 3-stage binary16 multiplier (unpack/classify, multiply, normalize/pack) with valid/ready.
// Truncates by default; defining FP16_MUL_RNE_EN adds round-to-nearest-even in the pack stage.
module fp16_mul_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic [TAG_W-1:0] out_tag
);

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic c_nan, c_inf, c_zero;

  // Exponent field 0 covers both true zero and subnormals, which are flushed.
  always_comb begin
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    c_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    c_inf  = a_inf | b_inf;
    c_zero = a_zero | b_zero;
  end

  logic             s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [10:0]      s1_mant_a, s1_mant_b;
  logic [5:0]       s1_esum;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_mant_a <= '0;
      s1_mant_b <= '0;
      s1_esum   <= '0;
      s1_tag    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= a[15] ^ b[15];
      s1_nan    <= c_nan;
      s1_inf    <= c_inf;
      s1_zero   <= c_zero;
      s1_mant_a <= {1'b1, a[9:0]};
      s1_mant_b <= {1'b1, b[9:0]};
      s1_esum   <= {1'b0, a[14:10]} + {1'b0, b[14:10]};
      s1_tag    <= in_tag;
    end
  end

  logic             s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [21:0]      s2_p;
  logic [5:0]       s2_esum;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_p     <= '0;
      s2_esum  <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
      s2_p     <= 22'(s1_mant_a) * 22'(s1_mant_b);
      s2_esum  <= s1_esum;
      s2_tag   <= s1_tag;
    end
  end

  logic [9:0]        frac_t, frac_r;
  logic signed [6:0] exp_t, exp_r;
  logic [15:0]       result;
`ifdef FP16_MUL_RNE_EN
  logic              guard, sticky;
  logic [10:0]       frac_inc;
`else
  logic              unused_low_bits;
  assign unused_low_bits = ^s2_p[9:0];
`endif

  // Product of two 1.x mantissas lies in [1,4); p[21] selects the extra exponent step.
  always_comb begin
    frac_t = '0;
    exp_t  = '0;
    frac_r = '0;
    exp_r  = '0;
    result = '0;
`ifdef FP16_MUL_RNE_EN
    guard    = 1'b0;
    sticky   = 1'b0;
    frac_inc = '0;
`endif
    if (s2_p[21]) begin
      frac_t = s2_p[20:11];
      exp_t  = $signed({1'b0, s2_esum}) - 7'sd14;
`ifdef FP16_MUL_RNE_EN
      guard  = s2_p[10];
      sticky = |s2_p[9:0];
`endif
    end else begin
      frac_t = s2_p[19:10];
      exp_t  = $signed({1'b0, s2_esum}) - 7'sd15;
`ifdef FP16_MUL_RNE_EN
      guard  = s2_p[9];
      sticky = |s2_p[8:0];
`endif
    end
`ifdef FP16_MUL_RNE_EN
    frac_inc = {1'b0, frac_t} + {10'd0, guard & (sticky | frac_t[0])};
    if (frac_inc[10]) begin
      frac_r = '0;
      exp_r  = exp_t + 7'sd1;
    end else begin
      frac_r = frac_inc[9:0];
      exp_r  = exp_t;
    end
`else
    frac_r = frac_t;
    exp_r  = exp_t;
`endif
    if (s2_nan)
      result = 16'h7E00;
    else if (s2_inf)
      result = {s2_sign, 5'h1F, 10'h000};
    else if (s2_zero)
      result = {s2_sign, 15'h0000};
    else if (exp_r >= 7'sd31)
      result = {s2_sign, 5'h1F, 10'h000};
    else if (exp_r <= 7'sd0)
      result = {s2_sign, 15'h0000};
    else
      result = {s2_sign, exp_r[4:0], frac_r};
  end

  // Data only loads for valid slots so the last product stays visible across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= 16'h0000;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        product <= result;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Directed self-checking bench for fp16_mul_pipe; expected products are hand-computed constants.
// The rounding vector's expectation follows FP16_MUL_RNE_EN when the bench is built with it.
module tb_fp16_mul_pipe;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

`ifdef FP16_MUL_RNE_EN
  localparam logic [15:0] EXP_RND = 16'h3E03;
`else
  localparam logic [15:0] EXP_RND = 16'h3E02;
`endif

  fp16_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_latency();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h3E00; b = 16'h3E00; in_tag = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_1: out_valid %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_2: out_valid %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b expected 1", out_valid); end
    checks++; if (product !== 16'h4080) begin errors++; $display("FAIL basic_product: got %h expected 4080", product); end
    checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL basic_tag: got %h expected 5", out_tag); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble: out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_sign_stream();
    logic [15:0] va [3] = '{16'hC000, 16'h3C00, 16'h7BFF};
    logic [15:0] vb [3] = '{16'h4200, 16'h4000, 16'h4000};
    logic [15:0] ve [3] = '{16'hC600, 16'h4000, 16'h7C00};
    int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got < 3) begin
          checks++; if (product !== ve[got] || out_tag !== 4'(got + 8)) begin errors++; $display("FAIL stream_result[%0d]: got %h tag %h expected %h tag %h", got, product, out_tag, ve[got], 4'(got + 8)); end
          checks++; if (cyc != got + 3) begin errors++; $display("FAIL stream_timing[%0d]: cycle %0d expected %0d", got, cyc, got + 3); end
        end
        got++;
      end
      if (cyc < 3) begin
        in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; in_tag = 4'(cyc + 8);
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL stream_count: got %0d results expected 3", got); end
  endtask

  task automatic test_specials();
    logic [15:0] va [4] = '{16'h0400, 16'h7C00, 16'hFC00, 16'h0001};
    logic [15:0] vb [4] = '{16'h3800, 16'h0000, 16'h4000, 16'h3C00};
    logic [15:0] ve [4] = '{16'h0000, 16'h7E00, 16'hFC00, 16'h0000};
    int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got < 4) begin
          checks++; if (product !== ve[got] || out_tag !== 4'(got + 1)) begin errors++; $display("FAIL special[%0d]: got %h tag %h expected %h tag %h", got, product, out_tag, ve[got], 4'(got + 1)); end
        end
        got++;
      end
      if (cyc < 4) begin
        in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; in_tag = 4'(cyc + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL special_count: got %0d results expected 4", got); end
  endtask

  task automatic test_rounding();
    int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++; if (product !== EXP_RND || out_tag !== 4'hA) begin errors++; $display("FAIL rounding: got %h tag %h expected %h tag a", product, out_tag, EXP_RND); end
        got++;
      end
      if (cyc == 0) begin
        in_valid = 1'b1; a = 16'h3E01; b = 16'h3C01; in_tag = 4'hA;
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rounding_count: got %0d results expected 1", got); end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [3] = '{16'h3C00, 16'h4000, 16'h3E00};
    logic [15:0] vb [3] = '{16'h4000, 16'h4000, 16'h4000};
    logic [15:0] ve [3] = '{16'h4000, 16'h4400, 16'h4200};
    int got = 1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; in_tag = 4'(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || product !== ve[0]) begin errors++; $display("FAIL bp_first: valid %b product %h expected 1 %h", out_valid, product, ve[0]); end
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || product !== ve[0] || out_tag !== 4'h1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: valid %b product %h tag %h in_ready %b expected 1 %h 1 0", s, out_valid, product, out_tag, in_ready, ve[0]); end
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got < 3) begin
          checks++; if (product !== ve[got] || out_tag !== 4'(got + 1)) begin errors++; $display("FAIL bp_drain[%0d]: got %h tag %h expected %h tag %h", got, product, out_tag, ve[got], 4'(got + 1)); end
        end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL bp_count: got %0d results expected 3", got); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h3E00; b = 16'h3E00; in_tag = 4'h1;
    @(negedge clk);
    a = 16'h3C00; b = 16'h4000; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || product !== 16'h4080) begin errors++; $display("FAIL rstmid_pre: valid %b product %h expected 1 4080", out_valid, product); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || product !== 16'h0000 || out_tag !== 4'h0) begin errors++; $display("FAIL rstmid_clear: valid %b product %h tag %h expected 0 0000 0", out_valid, product, out_tag); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_ghost: %0d results after reset expected 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_sign_stream();
    test_specials();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fp16_mul_pipe.md
Name: fp16_mul_pipe

Overview:
- 3-stage pipelined IEEE-754 binary16 multiplier with a valid/ready handshake.
- Sits directly upstream of the hidden-layer fp16 adder in each neuron: it forms weight x activation products that the adder accumulates.
- Numerics match the adder: subnormals are not carried and truncation is the default rounding.
- Carries a sideband tag (neuron/input index) with the same latency as the data.

Parameters:
- TAG_W, 4, width of the sideband tag passed through alongside each operand pair (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b/in_tag is valid this cycle.
- in_ready  output  1  block accepts a pair this cycle.
- a  input  16  fp16 operand (weight).
- b  input  16  fp16 operand (activation).
- in_tag  input  TAG_W  sideband tag for the pair.
- out_valid  output  1  product/out_tag are valid.
- out_ready  input  1  downstream (adder stage) consumes the product this cycle.
- product  output  16  fp16 result.
- out_tag  output  TAG_W  tag of the pair that produced the product.

Behaviour:
- Reset (asynchronous assert):
  - out_valid=0, product=16'h0000, out_tag=0.
  - All internal stage valid bits cleared; pairs in flight are dropped.
  - in_ready=1 in the first cycle after reset deassertion.
- Pipeline control:
  - advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - On advance: every stage shifts one step; stage 1 loads a/b/in_tag and valid bit = in_valid.
  - When advance=0: all stages hold; product/out_tag stay stable while out_valid=1.
- Transfer rules:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Latency is exactly 3 cycles from input transfer to out_valid, with no stall.
  - Throughput is 1 pair/cycle when out_ready is held high.
  - Bubbles (in_valid=0) propagate as invalid slots and never produce out_valid.
- Stage 1 (unpack/classify):
  - sign = a[15]^b[15].
  - Exponent field 0 is treated as zero (flush-to-zero on inputs).
  - Exponent field 31 is treated as inf/NaN.
  - mant = {1, frac} (11 bits). esum = ea + eb (6-bit unsigned, unbiased later).
- Stage 2 (multiply):
  - p = mant_a * mant_b, 22 bits.
  - Special-case flags and sign are pipelined alongside.
- Stage 3 (normalize/pack):
  - If p[21]: frac = p[20:11], e = esum - 14. Otherwise: frac = p[19:10], e = esum - 15.
  - Compute e as signed 7-bit.
  - e >= 31: result is {sign, 5'h1F, 10'h0} (infinity).
  - e <= 0: result is {sign, 15'h0} (signed zero); no subnormal outputs.
- Special-case priority (highest first):
  - Either input NaN (exp 31, frac != 0), or inf x zero: 16'h7E00.
  - Either input inf: {sign, 5'h1F, 10'h0}.
  - Either input zero/subnormal: {sign, 15'h0}.
  - Otherwise: normal path.
- Rounding: truncation (discarded product bits ignored).
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are legal and are the steady state.
  - in_valid while in_ready=0 is ignored; upstream must hold the pair.
- Reset mid-operation: in-flight pairs are lost and no partial product is emitted after reset.

Optional Feature:
- Macro: FP16_MUL_RNE_EN.
- Defined: stage 3 rounds to nearest, ties to even.
  - Guard = the first discarded bit; sticky = OR of the remaining discarded bits; lsb = frac[0].
  - Increment frac when guard & (sticky | lsb).
  - Mantissa carry-out sets frac=0 and e=e+1; the overflow check to infinity is applied after rounding.
  - Latency is unchanged (3 cycles).
- Not defined: truncation as above; no rounding logic is synthesized.

Test Plan:
- Basic and latency: a=16'h3E00 (1.5), b=16'h3E00, tag=4'h5, out_ready=1 -> product=16'h4080 (2.25), out_tag=4'h5, out_valid exactly 3 cycles after input transfer.
- Sign and streaming:
  - Back-to-back pairs 16'hC000 x 16'h4200, 16'h3C00 x 16'h4000, 16'h7BFF x 16'h4000 -> products 16'hC600, 16'h4000, 16'h7C00 (overflow to +inf) on consecutive cycles, tags in order.
- Specials:
  - 16'h0400 x 16'h3800 -> 16'h0000 (underflow).
  - 16'h7C00 x 16'h0000 -> 16'h7E00.
  - 16'hFC00 x 16'h4000 -> 16'hFC00.
  - 16'h0001 (subnormal) x 16'h3C00 -> 16'h0000.
- Backpressure:
  - Fill with 3 pairs, drop out_ready for 5 cycles -> in_ready=0, product/out_tag stable, no pair lost or duplicated.
  - Release -> 3 results emitted in order.
- Rounding: 16'h3E01 x 16'h3C01 -> 16'h3E02 without FP16_MUL_RNE_EN; 16'h3E03 with FP16_MUL_RNE_EN.
- Reset mid-operation: assert rst asynchronously (between clock edges) with 2 pairs in flight -> out_valid=0 and product=16'h0000 immediately; no result appears after release.
